// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with MEM/WB forwarding, operand select and load-use detect
module ex_operand_stage #(
  parameter logic [3:0] BUBBLE_CTRL = 4'd3,
  parameter int         XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            valid_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic [XLEN-1:0] reg1_d,
  input  logic [XLEN-1:0] reg2_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic            src1_sel_d,
  input  logic [1:0]      src2_sel_d,
  input  logic [3:0]      alu_ctrl_d,
  input  logic            reg_write_d,
  input  logic            mem_read_d,
  input  logic            mem_write_d,
  input  logic [4:0]      rd_m,
  input  logic            reg_write_m,
  input  logic [XLEN-1:0] result_m,
  input  logic [4:0]      rd_w,
  input  logic            reg_write_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [3:0]      alu_ctrl_e,
  output logic [XLEN-1:0] store_data_e,
  output logic [4:0]      rd_e,
  output logic            reg_write_e,
  output logic            mem_read_e,
  output logic            mem_write_e,
  output logic            valid_e,
  output logic            load_use_stall
);

  logic [XLEN-1:0] pc_e;
  logic [4:0]      rs1_e;
  logic [4:0]      rs2_e;
  logic [XLEN-1:0] reg1_e;
  logic [XLEN-1:0] reg2_e;
  logic [XLEN-1:0] imm_e;
  logic            src1_sel_e;
  logic [1:0]      src2_sel_e;

  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic [XLEN-1:0] wt1;
  logic [XLEN-1:0] wt2;

  // Forward from MEM first, then WB, otherwise the stored register value; x0 never forwards
  always_comb begin
    fwd1 = reg1_e;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs1_e))
      fwd1 = result_m;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_e))
      fwd1 = result_w;

    fwd2 = reg2_e;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs2_e))
      fwd2 = result_m;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_e))
      fwd2 = result_w;
  end

  // WB write-through on capture: the register file read in ID does not yet see the WB write
  always_comb begin
    wt1 = reg1_d;
    if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_d))
      wt1 = result_w;

    wt2 = reg2_d;
    if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_d))
      wt2 = result_w;
  end

  // Pipeline register: flush beats stall beats load; a stall refreshes reg1/reg2 with forwarded data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e     <= 1'b0;
      pc_e        <= '0;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg1_e      <= '0;
      reg2_e      <= '0;
      imm_e       <= '0;
      src1_sel_e  <= 1'b0;
      src2_sel_e  <= 2'b00;
      alu_ctrl_e  <= BUBBLE_CTRL;
      reg_write_e <= 1'b0;
      mem_read_e  <= 1'b0;
      mem_write_e <= 1'b0;
    end else if (flush_e) begin
      valid_e     <= 1'b0;
      pc_e        <= '0;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg1_e      <= '0;
      reg2_e      <= '0;
      imm_e       <= '0;
      src1_sel_e  <= 1'b0;
      src2_sel_e  <= 2'b00;
      alu_ctrl_e  <= BUBBLE_CTRL;
      reg_write_e <= 1'b0;
      mem_read_e  <= 1'b0;
      mem_write_e <= 1'b0;
    end else if (stall_e) begin
      reg1_e <= fwd1;
      reg2_e <= fwd2;
    end else begin
      valid_e     <= valid_d;
      pc_e        <= pc_d;
      rs1_e       <= rs1_d;
      rs2_e       <= rs2_d;
      rd_e        <= rd_d;
      reg1_e      <= wt1;
      reg2_e      <= wt2;
      imm_e       <= imm_d;
      src1_sel_e  <= src1_sel_d;
      src2_sel_e  <= src2_sel_d;
      alu_ctrl_e  <= alu_ctrl_d;
      reg_write_e <= reg_write_d;
      mem_read_e  <= mem_read_d;
      mem_write_e <= mem_write_d;
    end
  end

  // Operand selection, zeroed while EX holds a bubble
  always_comb begin
    operand1     = '0;
    operand2     = '0;
    store_data_e = '0;
    if (valid_e) begin
      operand1 = src1_sel_e ? pc_e : fwd1;
      case (src2_sel_e)
        2'b00:   operand2 = fwd2;
        2'b10:   operand2 = XLEN'(4);
        default: operand2 = imm_e;
      endcase
      store_data_e = fwd2;
    end
  end

  // Load-use hazard: a load in EX whose destination is read by the instruction in ID
  always_comb begin
    load_use_stall = valid_e & mem_read_e & (rd_e != 5'd0) & valid_d &
                     ((rd_e == rs1_d) | (rd_e == rs2_d));
  end

endmodule
